// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one EX load/store on the data bus, stalls the
// pipeline while it is outstanding, and returns aligned, extended load data to mem_wb.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [31:0] ex_reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [1:0]  dbg_state_o
);
    localparam logic [7:0] EXE_LB  = 8'hE0;
    localparam logic [7:0] EXE_LH  = 8'hE1;
    localparam logic [7:0] EXE_LW  = 8'hE3;
    localparam logic [7:0] EXE_LBU = 8'hE4;
    localparam logic [7:0] EXE_LHU = 8'hE5;
    localparam logic [7:0] EXE_SB  = 8'hE8;
    localparam logic [7:0] EXE_SH  = 8'hE9;
    localparam logic [7:0] EXE_SW  = 8'hEB;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_next;
    logic        r_req, r_we, r_wreg, r_is_load, r_abort, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata, r_cnt;
    logic [3:0]  r_be;
    logic [4:0]  r_wd;
    logic [7:0]  r_op;
    logic [1:0]  r_off;

    logic        w_is_load, w_is_store, w_is_mem, w_misalign, w_start, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_is_load  = (ex_aluop_i == EXE_LB) || (ex_aluop_i == EXE_LH) || (ex_aluop_i == EXE_LW) ||
                     (ex_aluop_i == EXE_LBU) || (ex_aluop_i == EXE_LHU);
        w_is_store = (ex_aluop_i == EXE_SB) || (ex_aluop_i == EXE_SH) || (ex_aluop_i == EXE_SW);
        w_is_mem   = w_is_load || w_is_store;
        w_misalign = (((ex_aluop_i == EXE_LH) || (ex_aluop_i == EXE_LHU) || (ex_aluop_i == EXE_SH))
                      && ex_mem_addr_i[0]) ||
                     (((ex_aluop_i == EXE_LW) || (ex_aluop_i == EXE_SW)) && (ex_mem_addr_i[1:0] != 2'b00));
        w_start    = w_is_mem && !w_misalign;
        w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);
    end

    // Store lanes are replicated so the slave can pick any enabled byte lane directly.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        case (ex_aluop_i)
            EXE_SB: begin
                w_be    = 4'b0001 << ex_mem_addr_i[1:0];
                w_wdata = {4{ex_reg2_i[7:0]}};
            end
            EXE_SH: begin
                w_be    = ex_mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{ex_reg2_i[15:0]}};
            end
            EXE_SW: w_wdata = ex_reg2_i;
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dbus_rdata_i[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (r_op)
            EXE_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            EXE_LBU: w_load_data = {24'd0, w_byte};
            EXE_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            EXE_LHU: w_load_data = {16'd0, w_half};
            default: w_load_data = dbus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mem) begin
                    wreg_o = 1'b0;
                    if (w_misalign) misalign_o = 1'b1;
                    else begin
                        stall_req_o = 1'b1;
                        w_next      = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wd_o        = r_wd;
                wreg_o      = 1'b0;
                wdata_o     = '0;
                stall_req_o = 1'b1;
                if (dbus_ack_i || w_timeout) w_next = S_DONE;
            end
            S_DONE: begin
                wd_o    = r_wd;
                wreg_o  = r_is_load && r_wreg && !r_abort;
                wdata_o = (r_is_load && !r_abort) ? r_rdata : '0;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            wreg_o      = 1'b0;
            wdata_o     = '0;
            stall_req_o = 1'b0;
            misalign_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_be <= '0; r_wdata <= '0;
            r_wd <= '0; r_wreg <= 1'b0; r_op <= '0; r_off <= '0; r_cnt <= '0;
            r_is_load <= 1'b0; r_abort <= 1'b0; r_err <= 1'b0; r_rdata <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_req     <= 1'b1;
                    r_we      <= w_is_store;
                    r_addr    <= {ex_mem_addr_i[31:2], 2'b00};
                    r_be      <= w_be;
                    r_wdata   <= w_wdata;
                    r_wd      <= wd_i;
                    r_wreg    <= wreg_i;
                    r_op      <= ex_aluop_i;
                    r_off     <= ex_mem_addr_i[1:0];
                    r_is_load <= w_is_load;
                    r_cnt     <= '0;
                    r_abort   <= 1'b0;
                end
                S_WAIT: begin
                    // An ack on the timeout cycle completes normally.
                    if (dbus_ack_i) begin
                        r_req   <= 1'b0;
                        r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus_req_o   = r_req;
    assign dbus_we_o    = r_we;
    assign dbus_addr_o  = r_addr;
    assign dbus_be_o    = r_be;
    assign dbus_wdata_o = r_wdata;
    assign bus_err_o    = r_err;
    assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a default-timeout instance for the bus/format cases and
// a TIMEOUT_CYCLES=4 instance (never acked) for the abort path.
module tb_mem_lsu;
    localparam logic [7:0] OP_NOP = 8'h21;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ex_aluop = OP_NOP;
    logic [31:0] ex_addr = '0, ex_reg2 = '0, wdata_i = '0, rdata = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0, ack = 1'b0;
    logic        to_ack = 1'b0;
    logic [31:0] to_rdata = '0;

    logic [4:0]  wd_o, to_wd;
    logic        wreg_o, stall, mis, berr, req, we;
    logic        to_wreg, to_stall, to_mis, to_berr, to_req, to_we;
    logic [31:0] wdata_o, baddr, bwdata, to_wdata, to_baddr, to_bwdata;
    logic [3:0]  be, to_be;
    logic [1:0]  st, to_st;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu u_dut (
        .clk(clk), .rst(rst), .ex_aluop_i(ex_aluop), .ex_mem_addr_i(ex_addr), .ex_reg2_i(ex_reg2),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stall_req_o(stall), .misalign_o(mis), .bus_err_o(berr),
        .dbus_req_o(req), .dbus_we_o(we), .dbus_addr_o(baddr), .dbus_be_o(be),
        .dbus_wdata_o(bwdata), .dbus_ack_i(ack), .dbus_rdata_i(rdata), .dbg_state_o(st)
    );

    mem_lsu #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .rst(rst), .ex_aluop_i(ex_aluop), .ex_mem_addr_i(ex_addr), .ex_reg2_i(ex_reg2),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(to_wd), .wreg_o(to_wreg),
        .wdata_o(to_wdata), .stall_req_o(to_stall), .misalign_o(to_mis), .bus_err_o(to_berr),
        .dbus_req_o(to_req), .dbus_we_o(to_we), .dbus_addr_o(to_baddr), .dbus_be_o(to_be),
        .dbus_wdata_o(to_bwdata), .dbus_ack_i(to_ack), .dbus_rdata_i(to_rdata), .dbg_state_o(to_st)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop(input logic wr);
        ex_aluop = OP_NOP; ex_addr = '0; ex_reg2 = '0; wd_i = 5'd4; wreg_i = wr; wdata_i = 32'h0000_0044;
    endtask

    task automatic run_mem(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] reg2, input logic [31:0] rd, input int delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_bw, input logic exp_we,
                           input logic [31:0] exp_wb, input logic exp_wen);
        ex_aluop = op; ex_addr = addr; ex_reg2 = reg2; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0BAD_0BAD;
        #1;
        check_eq({tag, ".idle_stall"}, 32'(stall), 32'd1);
        check_eq({tag, ".idle_wreg"}, 32'(wreg_o), 32'd0);
        check_eq({tag, ".idle_req"}, 32'(req), 32'd0);
        tick();
        for (int i = 0; i < delay; i++) begin
            check_eq({tag, ".wait_req"}, 32'(req), 32'd1);
            check_eq({tag, ".wait_addr"}, baddr, {addr[31:2], 2'b00});
            check_eq({tag, ".wait_be"}, 32'(be), 32'(exp_be));
            check_eq({tag, ".wait_stall"}, 32'(stall), 32'd1);
            tick();
        end
        check_eq({tag, ".req"}, 32'(req), 32'd1);
        check_eq({tag, ".addr"}, baddr, {addr[31:2], 2'b00});
        check_eq({tag, ".be"}, 32'(be), 32'(exp_be));
        check_eq({tag, ".we"}, 32'(we), 32'(exp_we));
        if (exp_we) check_eq({tag, ".bus_wdata"}, bwdata, exp_bw);
        check_eq({tag, ".wait_stall"}, 32'(stall), 32'd1);
        ack = 1'b1; rdata = rd;
        tick();
        ack = 1'b0; rdata = '0;
        #1;
        check_eq({tag, ".done_state"}, 32'(st), 32'd2);
        check_eq({tag, ".done_req"}, 32'(req), 32'd0);
        check_eq({tag, ".done_stall"}, 32'(stall), 32'd0);
        check_eq({tag, ".done_wreg"}, 32'(wreg_o), 32'(exp_wen));
        check_eq({tag, ".done_wd"}, 32'(wd_o), 32'd9);
        if (!exp_we) check_eq({tag, ".done_wdata"}, wdata_o, exp_wb);
        check_eq({tag, ".done_berr"}, 32'(berr), 32'd0);
        tick();
        set_nop(1'b0);
    endtask

    initial begin
        set_nop(1'b1);
        wdata_i = 32'h5555_5555;
        tick(); tick();
        check_eq("rst.req", 32'(req), 32'd0);
        check_eq("rst.stall", 32'(stall), 32'd0);
        check_eq("rst.wreg", 32'(wreg_o), 32'd0);
        check_eq("rst.wdata", wdata_o, 32'd0);
        check_eq("rst.state", 32'(st), 32'd0);
        check_eq("rst.be", 32'(be), 32'd0);
        rst = 1'b0;
        tick();

        ex_aluop = OP_NOP; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        #1;
        check_eq("pass.wreg", 32'(wreg_o), 32'd1);
        check_eq("pass.wd", 32'(wd_o), 32'd7);
        check_eq("pass.wdata", wdata_o, 32'hDEAD_BEEF);
        check_eq("pass.stall", 32'(stall), 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq("stray_ack.state", 32'(st), 32'd0);
        check_eq("stray_ack.req", 32'(req), 32'd0);
        set_nop(1'b0);
        tick();

        run_mem("lb",  OP_LB,  32'h0000_1003, 32'h0, 32'h8000_0000, 0, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1);
        run_mem("sh",  OP_SH,  32'h0000_2002, 32'h1234_ABCD, 32'h0, 0, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0, 1'b0);
        run_mem("sb",  OP_SB,  32'h0000_4001, 32'h0000_00A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b0);
        run_mem("sw",  OP_SW,  32'h0000_4008, 32'h1122_3344, 32'h0, 2, 4'b1111, 32'h1122_3344, 1'b1, 32'h0, 1'b0);
        run_mem("lhu", OP_LHU, 32'h0000_5002, 32'h0, 32'h8765_4321, 0, 4'b1111, 32'h0, 1'b0, 32'h0000_8765, 1'b1);
        run_mem("lh",  OP_LH,  32'h0000_5000, 32'h0, 32'h1234_8001, 1, 4'b1111, 32'h0, 1'b0, 32'hFFFF_8001, 1'b1);
        run_mem("lbu", OP_LBU, 32'h0000_5001, 32'h0, 32'h0000_F700, 0, 4'b1111, 32'h0, 1'b0, 32'h0000_00F7, 1'b1);
        run_mem("lw5", OP_LW,  32'h0000_7000, 32'h0, 32'hCAFE_F00D, 5, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1);

        ex_aluop = OP_LW; ex_addr = 32'h0000_3001; wreg_i = 1'b1;
        #1;
        check_eq("mis_lw.pulse", 32'(mis), 32'd1);
        check_eq("mis_lw.stall", 32'(stall), 32'd0);
        check_eq("mis_lw.wreg", 32'(wreg_o), 32'd0);
        tick();
        check_eq("mis_lw.req", 32'(req), 32'd0);
        check_eq("mis_lw.state", 32'(st), 32'd0);
        ex_aluop = OP_SH; ex_addr = 32'h0000_3003;
        #1;
        check_eq("mis_sh.pulse", 32'(mis), 32'd1);
        tick();
        check_eq("mis_sh.req", 32'(req), 32'd0);
        set_nop(1'b0);
        #1;
        check_eq("mis_clear", 32'(mis), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_aluop = OP_LW; ex_addr = 32'h0000_6000; wd_i = 5'd11; wreg_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("to.wait_req", 32'(to_req), 32'd1);
            check_eq("to.wait_berr", 32'(to_berr), 32'd0);
            check_eq("to.wait_stall", 32'(to_stall), 32'd1);
            tick();
        end
        check_eq("to.done_req", 32'(to_req), 32'd0);
        check_eq("to.done_berr", 32'(to_berr), 32'd1);
        check_eq("to.done_wreg", 32'(to_wreg), 32'd0);
        check_eq("to.done_state", 32'(to_st), 32'd2);
        check_eq("to.done_stall", 32'(to_stall), 32'd0);
        tick();
        set_nop(1'b0);
        #1;
        check_eq("to.idle_state", 32'(to_st), 32'd0);
        check_eq("to.idle_berr", 32'(to_berr), 32'd0);

        check_eq("rstw.pre_req", 32'(req), 32'd1);
        check_eq("rstw.pre_state", 32'(st), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstw.req", 32'(req), 32'd0);
        check_eq("rstw.state", 32'(st), 32'd0);
        ack = 1'b1; rdata = 32'h1357_9BDF;
        tick();
        ack = 1'b0; rdata = '0;
        check_eq("rstw.late_state", 32'(st), 32'd0);
        check_eq("rstw.late_wreg", 32'(wreg_o), 32'd0);
        check_eq("rstw.late_stall", 32'(stall), 32'd0);
        check_eq("rstw.late_req", 32'(req), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
